// File: rtl/rtsnoc_echo_mp_pkg.sv
// Shared types and helpers for the multi-port RTSNoC echo endpoint.
// Optional feature macro: RTSNOC_ECHO_CNT_EN (per-port echo counters).
package rtsnoc_echo_mp_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_READ,
    RX_GAP
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_WRITE
  } tx_state_t;

  localparam int LOC_W = 3;
  localparam int CNT_W = 16;

  // Header width: four coordinate fields plus the two local-port fields.
  function automatic int calc_hdr_w(input int size_x, input int size_y);
    return 2 * size_x + 2 * size_y + 2 * LOC_W;
  endfunction

endpackage

// File: rtl/rtsnoc_echo_mp_if.sv
// Router-side bus bundle for the multi-port echo endpoint.
// The master modport is the router, the slave modport is the echo block.
// Optional feature macro: RTSNOC_ECHO_CNT_EN adds echo_cnt_o.
interface rtsnoc_echo_mp_if #(
  parameter int N_PORTS = 2,
  parameter int BUS     = 26
);
  import rtsnoc_echo_mp_pkg::*;

  logic [N_PORTS*BUS-1:0] p_dout_i;
  logic [N_PORTS-1:0]     p_nd_i;
  logic [N_PORTS-1:0]     p_rd_o;
  logic [N_PORTS*BUS-1:0] p_din_o;
  logic [N_PORTS-1:0]     p_wr_o;
  logic [N_PORTS-1:0]     p_wait_i;
`ifdef RTSNOC_ECHO_CNT_EN
  logic [N_PORTS*CNT_W-1:0] echo_cnt_o;

  modport master (
    output p_dout_i, p_nd_i, p_wait_i,
    input  p_rd_o, p_din_o, p_wr_o, echo_cnt_o
  );

  modport slave (
    input  p_dout_i, p_nd_i, p_wait_i,
    output p_rd_o, p_din_o, p_wr_o, echo_cnt_o
  );
`else
  modport master (
    output p_dout_i, p_nd_i, p_wait_i,
    input  p_rd_o, p_din_o, p_wr_o
  );

  modport slave (
    input  p_dout_i, p_nd_i, p_wait_i,
    output p_rd_o, p_din_o, p_wr_o
  );
`endif

endinterface

// File: rtl/rtsnoc_echo_fifo.sv
// Synchronous FIFO, W bits wide, 2**AW entries, with full/empty flags.
// Push when full and pop when empty are ignored; head is the oldest entry.
module rtsnoc_echo_fifo #(
  parameter int W  = 26,
  parameter int AW = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  import rtsnoc_echo_mp_pkg::*;

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**AW.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rtsnoc_echo_mp.sv
// N-port RTSNoC loopback endpoint. Each port owns a FIFO, an RX FSM that
// pops the router and a TX FSM that writes back the address-swapped packet.
// Optional feature macro: RTSNOC_ECHO_CNT_EN (16-bit accepted-write counter per port).
module rtsnoc_echo_mp
  import rtsnoc_echo_mp_pkg::*;
#(
  parameter int SOC_SIZE_X     = 1,
  parameter int SOC_SIZE_Y     = 1,
  parameter int NOC_DATA_WIDTH = 16,
  parameter int N_PORTS        = 2,
  parameter int FIFO_AW        = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rtsnoc_echo_mp_if.slave bus
);

  localparam int HDR     = calc_hdr_w(SOC_SIZE_X, SOC_SIZE_Y);
  localparam int BUS     = NOC_DATA_WIDTH + HDR;
  localparam int XY_HALF = SOC_SIZE_X + SOC_SIZE_Y;

  // Swap the destination and source (x,y) blocks and the local-port fields.
  function automatic logic [BUS-1:0] swap_addr(input logic [BUS-1:0] pkt);
    logic [XY_HALF-1:0]        dst_xy;
    logic [XY_HALF-1:0]        src_xy;
    logic [LOC_W-1:0]          dst_loc;
    logic [LOC_W-1:0]          src_loc;
    logic [NOC_DATA_WIDTH-1:0] data;
    {dst_xy, src_xy, dst_loc, src_loc, data} = pkt;
    return {src_xy, dst_xy, src_loc, dst_loc, data};
  endfunction

  logic [N_PORTS-1:0]     rd_v;
  logic [N_PORTS-1:0]     wr_v;
  logic [N_PORTS*BUS-1:0] din_v;
`ifdef RTSNOC_ECHO_CNT_EN
  logic [N_PORTS*CNT_W-1:0] cnt_v;
  assign bus.echo_cnt_o = cnt_v;
`endif

  assign bus.p_rd_o  = rd_v;
  assign bus.p_wr_o  = wr_v;
  assign bus.p_din_o = din_v;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port
    rx_state_t      rx_state;
    rx_state_t      rx_next;
    tx_state_t      tx_state;
    tx_state_t      tx_next;
    logic           rd_q;
    logic           wr_q;
    logic [BUS-1:0] din_q;
    logic [BUS-1:0] dout_k;
    logic           nd_k;
    logic           stall_k;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic [BUS-1:0] head;

    assign dout_k  = bus.p_dout_i[k*BUS +: BUS];
    assign nd_k    = bus.p_nd_i[k];
    assign stall_k = bus.p_wait_i[k];

    // The router output is sampled on the edge that ends the read cycle.
    assign push = (rx_state == RX_READ);
    // A write is accepted on an edge where it is presented and not stalled.
    assign pop  = (tx_state == TX_WRITE) && !stall_k;

    rtsnoc_echo_fifo #(
      .W  (BUS),
      .AW (FIFO_AW)
    ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (push),
      .push_data (dout_k),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
    );

    // RX next state: read only with room in the FIFO, then one gap cycle
    // to ignore the router's not-yet-updated nd.
    always_comb begin
      rx_next = rx_state;
      case (rx_state)
        RX_IDLE: if (nd_k && !full) rx_next = RX_READ;
        RX_READ: rx_next = RX_GAP;
        RX_GAP:  rx_next = RX_IDLE;
        default: rx_next = RX_IDLE;
      endcase
    end

    // RX state register with the registered read strobe.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rx_state <= RX_IDLE;
        rd_q     <= 1'b0;
      end else begin
        rx_state <= rx_next;
        rd_q     <= (rx_next == RX_READ);
      end
    end

    // TX next state: present the head packet until the router takes it.
    always_comb begin
      tx_next = tx_state;
      case (tx_state)
        TX_IDLE:  if (!empty) tx_next = TX_WRITE;
        TX_WRITE: if (!stall_k) tx_next = TX_IDLE;
        default:  tx_next = TX_IDLE;
      endcase
    end

    // TX state register; din is loaded once on entry and held through stalls.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        tx_state <= TX_IDLE;
        wr_q     <= 1'b0;
        din_q    <= '0;
      end else begin
        tx_state <= tx_next;
        wr_q     <= (tx_next == TX_WRITE);
        if ((tx_state == TX_IDLE) && (tx_next == TX_WRITE)) din_q <= swap_addr(head);
      end
    end

    assign rd_v[k]            = rd_q;
    assign wr_v[k]            = wr_q;
    assign din_v[k*BUS +: BUS] = din_q;

`ifdef RTSNOC_ECHO_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Accepted-write counter, wrapping at 2**16.
    always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else if (pop) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign cnt_v[k*CNT_W +: CNT_W] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_rtsnoc_echo_mp.sv
// Scoreboard bench for rtsnoc_echo_mp (two ports, FIFO depth 4).
// Build with +define+RTSNOC_ECHO_CNT_EN to also exercise the echo counters.
module tb_rtsnoc_echo_mp;

  localparam int BUS = 26;
  localparam int NP  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rtsnoc_echo_mp_if #(.N_PORTS(NP), .BUS(BUS)) bus ();

  rtsnoc_echo_mp #(
    .SOC_SIZE_X     (1),
    .SOC_SIZE_Y     (1),
    .NOC_DATA_WIDTH (16),
    .N_PORTS        (NP),
    .FIFO_AW        (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int rd_cnt [NP];
  int wr_cnt [NP];
  logic rd_pend [NP];

  // Router-side packet queues and expected echo queues, one per port.
  logic [BUS-1:0] rq0 [$];
  logic [BUS-1:0] rq1 [$];
  logic [BUS-1:0] eq0 [$];
  logic [BUS-1:0] eq1 [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [BUS-1:0] mk(input bit dx, input bit dy, input logic [2:0] dl,
                                        input bit sx, input bit sy, input logic [2:0] sl,
                                        input logic [15:0] d);
    return {dx, dy, sx, sy, dl, sl, d};
  endfunction

  task automatic drive_router();
    bus.p_nd_i[0]         = (rq0.size() != 0);
    bus.p_nd_i[1]         = (rq1.size() != 0);
    bus.p_dout_i[0 +: BUS]   = (rq0.size() != 0) ? rq0[0] : '0;
    bus.p_dout_i[BUS +: BUS] = (rq1.size() != 0) ? rq1[0] : '0;
  endtask

  task automatic inject(input int k, input bit dx, input bit dy, input logic [2:0] dl,
                        input bit sx, input bit sy, input logic [2:0] sl, input logic [15:0] d);
    logic [BUS-1:0] pkt;
    logic [BUS-1:0] exp;
    pkt = mk(dx, dy, dl, sx, sy, sl, d);
    exp = mk(sx, sy, sl, dx, dy, dl, d);
    if (k == 0) begin rq0.push_back(pkt); eq0.push_back(exp); end
    else        begin rq1.push_back(pkt); eq1.push_back(exp); end
    drive_router();
  endtask

  // One clock: observe this cycle's outputs, then advance past the next edge.
  task automatic step();
    for (int k = 0; k < NP; k++) begin
      logic [BUS-1:0] d;
      logic [BUS-1:0] e;
      int es;
      d  = bus.p_din_o[k*BUS +: BUS];
      es = (k == 0) ? eq0.size() : eq1.size();
      if (bus.p_rd_o[k]) begin
        rd_cnt[k]++;
        rd_pend[k] = 1'b1;
      end
      if (bus.p_wr_o[k]) begin
        wr_cnt[k]++;
        if (es == 0) begin
          check($sformatf("spurious_wr_p%0d", k), 1, 0);
        end else begin
          e = (k == 0) ? eq0[0] : eq1[0];
          if (!bus.p_wait_i[k]) begin
            check($sformatf("echo_p%0d", k), d, e);
            if (k == 0) void'(eq0.pop_front());
            else        void'(eq1.pop_front());
          end else begin
            check($sformatf("hold_p%0d", k), d, e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NP; k++) begin
      if (rd_pend[k]) begin
        rd_pend[k] = 1'b0;
        if (k == 0 && rq0.size() != 0) void'(rq0.pop_front());
        if (k == 1 && rq1.size() != 0) void'(rq1.pop_front());
      end
    end
    drive_router();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string tag, input int budget);
    int left;
    left = budget;
    while ((eq0.size() + eq1.size()) != 0 && left > 0) begin
      step();
      left--;
    end
    check(tag, eq0.size() + eq1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int r0;
    for (int k = 0; k < NP; k++) begin
      rd_cnt[k]  = 0;
      wr_cnt[k]  = 0;
      rd_pend[k] = 1'b0;
    end
    rst          = 1'b1;
    bus.p_wait_i = '0;
    drive_router();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd",  bus.p_rd_o, 0);
    check("rst_wr",  bus.p_wr_o, 0);
    check("rst_din", bus.p_din_o, 0);
    rst = 1'b0;
    run(2);

    // Basic echo on port 0 with cycle-exact latency.
    inject(0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 3'd5, 16'hBEEF);
    check("t1_rd_c0", bus.p_rd_o[0], 0);
    step();
    check("t1_rd_c1", bus.p_rd_o[0], 1);
    step();
    check("t1_rd_c2", bus.p_rd_o[0], 0);
    check("t1_wr_c2", bus.p_wr_o[0], 0);
    step();
    check("t1_wr_c3",  bus.p_wr_o[0], 1);
    check("t1_din_c3", bus.p_din_o[0 +: BUS], 26'h1AABEEF);
    check("t1_wr1_idle", bus.p_wr_o[1], 0);
    step();
    check("t1_wr_c4", bus.p_wr_o[0], 0);
    check("t1_sb_empty", eq0.size(), 0);
    run(3);

    // Ten-cycle stall during a write: held stable, accepted exactly once.
    bus.p_wait_i[0] = 1'b1;
    inject(0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 3'd6, 16'h1234);
    run(3);
    check("t2_wr_on", bus.p_wr_o[0], 1);
    w0 = wr_cnt[0];
    run(10);
    check("t2_wr_cycles", wr_cnt[0] - w0, 10);
    check("t2_pending", eq0.size(), 1);
    bus.p_wait_i[0] = 1'b0;
    step();
    check("t2_single_pop", eq0.size(), 0);
    check("t2_wr_off", bus.p_wr_o[0], 0);
    run(6);

    // Backpressure: six packets on port 1 while stalled, only four fit.
    bus.p_wait_i[1] = 1'b1;
    r0 = rd_cnt[1];
    for (int i = 0; i < 6; i++)
      inject(1, i[0], i[1], 3'(i), i[1], i[0], 3'(7 - i), 16'hA000 + 16'(i * 17));
    run(40);
    check("t3_rd_pulses", rd_cnt[1] - r0, 4);
    check("t3_nd_pending", bus.p_nd_i[1], 1);
    check("t3_router_left", rq1.size(), 2);
    bus.p_wait_i[1] = 1'b0;
    drain("t3_drain", 100);
    run(4);

    // Simultaneous receive on both ports.
    inject(0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd4, 16'h5555);
    inject(1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd7, 16'hAAAA);
    run(3);
    check("t4_wr_both", bus.p_wr_o, 2'b11);
    check("t4_din_p0", bus.p_din_o[0 +: BUS],   mk(1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 3'd3, 16'h5555));
    check("t4_din_p1", bus.p_din_o[BUS +: BUS], mk(1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 3'd0, 16'hAAAA));
    drain("t4_drain", 20);
    run(4);

    // Reset while writing with more packets queued.
    bus.p_wait_i[0] = 1'b1;
    for (int i = 0; i < 3; i++)
      inject(0, 1'b1, 1'b0, 3'(i), 1'b0, 1'b1, 3'(i + 1), 16'hC000 + 16'(i));
    run(12);
    check("t5_in_write", bus.p_wr_o[0], 1);
    rst = 1'b1;
    step();
    rq0.delete();
    rq1.delete();
    eq0.delete();
    eq1.delete();
    drive_router();
    check("t5_rd_zero",  bus.p_rd_o, 0);
    check("t5_wr_zero",  bus.p_wr_o, 0);
    check("t5_din_zero", bus.p_din_o, 0);
    rst             = 1'b0;
    bus.p_wait_i[0] = 1'b0;
    w0 = wr_cnt[0] + wr_cnt[1];
    run(15);
    check("t5_no_echo", wr_cnt[0] + wr_cnt[1] - w0, 0);

    // Three echoes on port 0 after the reset.
    for (int i = 0; i < 3; i++)
      inject(0, 1'b0, 1'b1, 3'(i), 1'b1, 1'b0, 3'(6 - i), 16'h0F00 + 16'(i));
    drain("t6_drain", 40);
    run(2);
`ifdef RTSNOC_ECHO_CNT_EN
    check("t6_cnt_p0", bus.echo_cnt_o[15:0], 16'd3);
    check("t6_cnt_p1", bus.echo_cnt_o[31:16], 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
